// File: rtl/clk_period_meter.sv
// clk_period_meter
//   Measures period and high time of a slow square wave in clk cycles.
//   The input is synchronized into the clk domain. A coherent period/high-time
//   pair is published on every rising edge after the first one, which only
//   arms the measurement. Loss of the input is flagged on stale.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   sigin      in   asynchronous slow square wave
//   rise       out  one-cycle strobe per synchronized rising edge
//   period     out  cycles between the last two rising edges
//   high_time  out  cycles sigin was high within that period
//   valid      out  one-cycle pulse when period/high_time update
//   stale      out  level, no valid measurement or input timed out
//
// state   | meaning
// IDLE    | no reference edge yet (after reset or timeout); next rise arms
// MEASURE | counting from the last rise; next rise publishes
module clk_period_meter #(
   parameter int CNT_W       = 26,
   parameter int TIMEOUT_CYC = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sigin,
   output logic             rise,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             stale
);

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam logic [CNT_W-1:0] TC  = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t           state_q, state_d;
   logic             s1, s2, s3;
   logic [CNT_W-1:0] cnt, hi_cap;
   logic             rise_c, fall_c;
   logic             arm, publish, timeout;

   assign rise_c = s2 & ~s3;
   assign fall_c = ~s2 & s3;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // A rise coinciding with the terminal count wins over the timeout.
   always_comb begin
      state_d = state_q;
      arm     = 1'b0;
      publish = 1'b0;
      timeout = 1'b0;
      case (state_q)
         IDLE: begin
            if (rise_c) begin
               arm     = 1'b1;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (rise_c) begin
               publish = 1'b1;
            end else if (cnt == TC) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         cnt       <= '0;
         hi_cap    <= '0;
         rise      <= 1'b0;
         valid     <= 1'b0;
         period    <= '0;
         high_time <= '0;
         stale     <= 1'b1;
      end else begin
         s1    <= sigin;
         s2    <= s1;
         s3    <= s2;
         rise  <= rise_c;
         valid <= publish;

         // Counter saturates at the timeout value so it can never wrap.
         if (arm || publish)
            cnt <= ONE;
         else if (state_q == MEASURE && cnt != TC)
            cnt <= cnt + ONE;

         // Only the last fall before the publishing rise survives.
         if (state_q == MEASURE && fall_c)
            hi_cap <= cnt;

         if (publish) begin
            period    <= cnt;
            high_time <= hi_cap;
            stale     <= 1'b0;
         end else if (timeout) begin
            stale <= 1'b1;
         end
      end
   end

endmodule
